// File: rtl/ps2_host_tx_if.sv
// Handshake and PS/2 line bundle for the host-to-device transmitter.
// slave = transmitter side, master = byte source plus line/pad side.
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       ps2c_in;
  logic       ps2d_in;
  logic       ps2c_oe;
  logic       ps2d_oe;
  logic       busy;
  logic       tx_done;
  logic       tx_err;

  modport master (
    output tx_valid, tx_data, ps2c_in, ps2d_in,
    input  tx_ready, ps2c_oe, ps2d_oe, busy, tx_done, tx_err
  );

  modport slave (
    input  tx_valid, tx_data, ps2c_in, ps2d_in,
    output tx_ready, ps2c_oe, ps2d_oe, busy, tx_done, tx_err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits LSB first,
// odd parity, stop, then device ACK. Lines are open-drain (oe=1 pulls low).
//
// state     | meaning
// IDLE      | bus released, ready for a byte
// INHIBIT   | ps2c held low
// START     | ps2c and ps2d low (start bit presented)
// SEND      | ps2c released, shifting bits on device clock falls
// ACK       | waiting for fall 11 to sample device ACK
// WAIT_IDLE | waiting for both lines to return high
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int SETUP_CYCLES   = 200,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input logic         clk,
  input logic         rst_n,
  ps2_host_tx_if.slave bus
);

  localparam int PH_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FL_W   = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  logic [1:0]      c_sync;
  logic [1:0]      d_sync;
  logic            c_filt;
  logic            d_filt;
  logic            c_fall;
  logic [FL_W-1:0] c_fcnt;
  logic [FL_W-1:0] d_fcnt;

  state_t          state;
  logic [7:0]      data_q;
  logic            par_q;
  logic [3:0]      bit_idx;
  logic [PH_W-1:0] ph_cnt;
  logic [WD_W-1:0] wd_cnt;
  logic            c_oe;
  logic            d_oe;
  logic            ready_q;
  logic            done_q;
  logic            err_q;
  logic            wd_active;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_sync <= 2'b11;
      d_sync <= 2'b11;
    end else begin
      c_sync <= {c_sync[0], bus.ps2c_in};
      d_sync <= {d_sync[0], bus.ps2d_in};
    end
  end

  // Filtered value changes only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_filt <= 1'b1;
      c_fcnt <= '0;
      c_fall <= 1'b0;
    end else begin
      c_fall <= 1'b0;
      if (c_sync[1] == c_filt) begin
        c_fcnt <= '0;
      end else if (c_fcnt == FL_W'(FILTER_LEN - 1)) begin
        c_filt <= c_sync[1];
        c_fcnt <= '0;
        c_fall <= c_filt;
      end else begin
        c_fcnt <= c_fcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_filt <= 1'b1;
      d_fcnt <= '0;
    end else begin
      if (d_sync[1] == d_filt) begin
        d_fcnt <= '0;
      end else if (d_fcnt == FL_W'(FILTER_LEN - 1)) begin
        d_filt <= d_sync[1];
        d_fcnt <= '0;
      end else begin
        d_fcnt <= d_fcnt + 1'b1;
      end
    end
  end

  assign wd_active = (state == SEND) || (state == ACK) || (state == WAIT_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      data_q  <= '0;
      par_q   <= 1'b0;
      bit_idx <= '0;
      ph_cnt  <= '0;
      wd_cnt  <= '0;
      c_oe    <= 1'b0;
      d_oe    <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (wd_active) begin
        wd_cnt <= wd_cnt - 1'b1;
      end
      case (state)
        IDLE: begin
          c_oe    <= 1'b0;
          d_oe    <= 1'b0;
          ready_q <= 1'b1;
          if (bus.tx_valid && ready_q) begin
            data_q  <= bus.tx_data;
            par_q   <= ~^bus.tx_data;
            ready_q <= 1'b0;
            c_oe    <= 1'b1;
            ph_cnt  <= PH_W'(INHIBIT_CYCLES - 1);
            state   <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (ph_cnt == '0) begin
            d_oe   <= 1'b1;
            ph_cnt <= PH_W'(SETUP_CYCLES - 1);
            state  <= START;
          end else begin
            ph_cnt <= ph_cnt - 1'b1;
          end
        end
        START: begin
          if (ph_cnt == '0) begin
            c_oe    <= 1'b0;
            wd_cnt  <= WD_W'(TIMEOUT_CYCLES - 1);
            bit_idx <= '0;
            state   <= SEND;
          end else begin
            ph_cnt <= ph_cnt - 1'b1;
          end
        end
        SEND: begin
          // Start bit stays on ps2d until the first device fall.
          if (c_fall) begin
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx < 4'd8) begin
              d_oe <= ~data_q[bit_idx[2:0]];
            end else if (bit_idx == 4'd8) begin
              d_oe <= ~par_q;
            end else begin
              d_oe  <= 1'b0;
              state <= ACK;
            end
          end
        end
        ACK: begin
          if (c_fall) begin
            if (!d_filt) begin
              state <= WAIT_IDLE;
            end else begin
              err_q   <= 1'b1;
              ready_q <= 1'b1;
              state   <= IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          if (c_filt && d_filt) begin
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          c_oe  <= 1'b0;
          d_oe  <= 1'b0;
          state <= IDLE;
        end
      endcase
      // Watchdog wins over any same-cycle ACK/done decision.
      if (wd_active && wd_cnt == '0) begin
        c_oe    <= 1'b0;
        d_oe    <= 1'b0;
        done_q  <= 1'b0;
        err_q   <= 1'b1;
        ready_q <= 1'b1;
        state   <= IDLE;
      end
    end
  end

  assign bus.tx_ready = ready_q;
  assign bus.ps2c_oe  = c_oe;
  assign bus.ps2d_oe  = d_oe;
  assign bus.busy     = (state != IDLE);
  assign bus.tx_done  = done_q;
  assign bus.tx_err   = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;

  localparam int INHIBIT = 100;
  localparam int SETUP   = 20;
  localparam int FILT    = 8;
  localparam int TIMEOUT = 3000;
  localparam int HALF    = 40;

  logic clk = 1'b0;
  logic rst_n;
  logic model_c = 1'b1;
  logic model_d = 1'b1;
  logic glitch  = 1'b0;
  logic c_line;
  logic d_line;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done = 0, n_err = 0, n_both = 0, n_long = 0, n_rdy_bad = 0;
  int n_oe_idle = 0, n_inh = 0, n_setup = 0;
  logic prev_done = 1'b0, prev_err = 1'b0;

  ps2_host_tx_if bus();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INHIBIT),
    .SETUP_CYCLES  (SETUP),
    .FILTER_LEN    (FILT),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign c_line      = ~bus.ps2c_oe & model_c & ~glitch;
  assign d_line      = ~bus.ps2d_oe & model_d;
  assign bus.ps2c_in = c_line;
  assign bus.ps2d_in = d_line;

  always @(negedge clk) begin
    if (bus.tx_done === 1'b1) n_done++;
    if (bus.tx_err === 1'b1) n_err++;
    if (bus.tx_done === 1'b1 && bus.tx_err === 1'b1) n_both++;
    if ((bus.tx_done === 1'b1 && prev_done) || (bus.tx_err === 1'b1 && prev_err)) n_long++;
    if (bus.tx_done === 1'b1 && bus.tx_ready !== 1'b1) n_rdy_bad++;
    if (bus.busy === 1'b0 && (bus.ps2c_oe !== 1'b0 || bus.ps2d_oe !== 1'b0)) n_oe_idle++;
    if (bus.ps2c_oe === 1'b1 && bus.ps2d_oe === 1'b0) n_inh++;
    if (bus.ps2c_oe === 1'b1 && bus.ps2d_oe === 1'b1) n_setup++;
    prev_done = (bus.tx_done === 1'b1);
    prev_err  = (bus.tx_err === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc = 1'b0;
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = b;
    for (int i = 0; i < 200; i++) begin
      if (bus.tx_ready === 1'b1) begin
        acc = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus.tx_valid = 1'b0;
    check("accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_reached", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  // Device: waits for ps2c released with ps2d low, then clocks; samples on rises 1..10,
  // drives ACK low after rise 10 so the host sees it at fall 11.
  task automatic device_frame(input bit ack, input int glitch_clk, input int rst_clk,
                              output logic [7:0] rbyte, output logic rpar, output logic rstop);
    logic [9:0] bits = '0;
    bit found = 1'b0;
    rbyte = '0;
    rpar  = 1'b0;
    rstop = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (c_line === 1'b1 && d_line === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check("start_seen", 32'(found), 32'd1);
    if (!found) return;
    repeat (20) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      model_c = 1'b0;
      repeat (HALF) @(negedge clk);
      if (rst_clk == k) begin
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_c_oe", 32'(bus.ps2c_oe), 32'd0);
        check("rst_d_oe", 32'(bus.ps2d_oe), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst_n   = 1'b1;
        model_c = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(bus.tx_ready), 32'd1);
        return;
      end
      model_c = 1'b1;
      if (k <= 10) bits[k-1] = d_line;
      if (k == 10 && ack) model_d = 1'b0;
      if (glitch_clk == k) begin
        repeat (HALF / 4) @(negedge clk);
        glitch = 1'b1;
        repeat (FILT / 2) @(negedge clk);
        glitch = 1'b0;
        repeat (HALF - HALF / 4 - FILT / 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      if (k == 11) model_d = 1'b1;
    end
    model_d = 1'b1;
    rbyte   = bits[7:0];
    rpar    = bits[8];
    rstop   = bits[9];
  endtask

  task automatic frame_run(input string tag, input logic [7:0] b, input logic exp_par,
                           input bit ack, input int glitch_clk, input bit spurious);
    int d0, e0, i0, s0;
    logic [7:0] rb;
    logic rp, rs;
    d0 = n_done; e0 = n_err; i0 = n_inh; s0 = n_setup;
    send_byte(b);
    fork
      device_frame(ack, glitch_clk, 0, rb, rp, rs);
      begin
        if (spurious) begin
          repeat (300) @(negedge clk);
          bus.tx_valid = 1'b1;
          bus.tx_data  = 8'h99;
          @(negedge clk);
          bus.tx_valid = 1'b0;
        end
      end
    join
    wait_idle();
    check({tag, "_byte"},  32'(rb), 32'(b));
    check({tag, "_par"},   32'(rp), 32'(exp_par));
    check({tag, "_stop"},  32'(rs), 32'd1);
    check({tag, "_inh"},   32'(n_inh - i0), 32'(INHIBIT));
    check({tag, "_setup"}, 32'(n_setup - s0), 32'(SETUP));
    check({tag, "_done"},  32'(n_done - d0), ack ? 32'd1 : 32'd0);
    check({tag, "_err"},   32'(n_err - e0), ack ? 32'd0 : 32'd1);
    check({tag, "_oe"},    32'({bus.ps2c_oe, bus.ps2d_oe}), 32'd0);
    check({tag, "_ready"}, 32'(bus.tx_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int d0, e0, k;
    bit found;
    logic [7:0] rb;
    logic rp, rs;

    rst_n = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_c_oe", 32'(bus.ps2c_oe), 32'd0);
    check("reset_d_oe", 32'(bus.ps2d_oe), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_pulses", 32'({bus.tx_done, bus.tx_err}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", 32'(bus.tx_ready), 32'd1);

    frame_run("t1_ed", 8'hED, 1'b1, 1'b1, 0, 1'b0);
    frame_run("t2_01", 8'h01, 1'b0, 1'b1, 0, 1'b0);
    frame_run("t2_ff", 8'hFF, 1'b1, 1'b1, 0, 1'b0);
    frame_run("t2_00", 8'h00, 1'b1, 1'b1, 0, 1'b0);
    frame_run("t3_noack", 8'h5A, 1'b1, 1'b0, 0, 1'b0);

    // Device never clocks: watchdog from SEND entry.
    d0 = n_done; e0 = n_err;
    send_byte(8'h33);
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.ps2c_oe === 1'b0 && bus.ps2d_oe === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check("t4_send_entry", 32'(found), 32'd1);
    k = 0;
    for (int i = 0; i < TIMEOUT + 100; i++) begin
      @(negedge clk);
      k++;
      if (bus.tx_err === 1'b1) break;
    end
    check("t4_wd_latency", 32'(k), 32'(TIMEOUT));
    check("t4_oe", 32'({bus.ps2c_oe, bus.ps2d_oe}), 32'd0);
    wait_idle();
    check("t4_err", 32'(n_err - e0), 32'd1);
    check("t4_done", 32'(n_done - d0), 32'd0);

    // Reset during bit 4, then a clean frame.
    d0 = n_done; e0 = n_err;
    send_byte(8'hA5);
    device_frame(1'b1, 0, 5, rb, rp, rs);
    repeat (5) @(negedge clk);
    check("t5_no_pulse", 32'((n_done - d0) + (n_err - e0)), 32'd0);
    frame_run("t5_after", 8'h3C, 1'b1, 1'b1, 0, 1'b0);

    // Short ps2c glitch plus a stray tx_valid pulse while busy.
    frame_run("t6_glitch", 8'h96, 1'b1, 1'b1, 3, 1'b1);
    repeat (30) @(negedge clk);
    check("t6_no_extra", 32'(bus.busy), 32'd0);

    // Back-to-back: second byte held valid while the first frame runs.
    d0 = n_done;
    send_byte(8'h12);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hC3;
    device_frame(1'b1, 0, 0, rb, rp, rs);
    check("t6_b2b_first", 32'(rb), 32'h12);
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (n_done > d0 && bus.busy === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus.tx_valid = 1'b0;
    check("t6_b2b_accept", 32'(found), 32'd1);
    device_frame(1'b1, 0, 0, rb, rp, rs);
    wait_idle();
    check("t6_b2b_second", 32'(rb), 32'hC3);
    check("t6_b2b_par", 32'(rp), 32'd1);
    check("t6_b2b_done", 32'(n_done - d0), 32'd2);

    check("pulse_overlap", 32'(n_both), 32'd0);
    check("pulse_width", 32'(n_long), 32'd0);
    check("done_ready", 32'(n_rdy_bad), 32'd0);
    check("oe_in_idle", 32'(n_oe_idle), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
